// File: rtl/fir_pkg.sv
// Shared definitions for the symmetric multi-channel FIR.
// Holds the controller state type, the width and size helpers shared by the
// interface, history bank and top level, and the reset coefficient table.
// No ports: this is a package imported by the other files.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of mirrored tap pairs; index HALF is the centre tap.
    function automatic int half_of(input int ntaps);
        return (ntaps - 1) / 2;
    endfunction

    // Channel index width, kept at one bit even for a single channel.
    function automatic int chw_of(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Width of the tap index / coefficient address (0..HALF).
    function automatic int kw_of(input int ntaps);
        return $clog2(half_of(ntaps) + 1);
    endfunction

    // Accumulator width: one product plus growth for HALF+1 additions.
    function automatic int accw_of(input int dw, input int cw, input int ntaps);
        return dw + cw + 1 + $clog2(half_of(ntaps) + 1);
    endfunction

    // Coefficients loaded at reset, index 0 is the outermost tap pair and
    // index 10 the centre of the default 21-tap response.
    function automatic int default_coef(input int idx);
        case (idx)
            0:       return 2;
            1:       return 10;
            2:       return 16;
            3:       return 28;
            4:       return 43;
            5:       return 60;
            6:       return 78;
            7:       return 95;
            8:       return 111;
            9:       return 122;
            10:      return 128;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/fir_sym_mac_if.sv
// Sample, coefficient and result signals of the symmetric FIR.
// master: the producer/consumer side (ADC capture, coefficient writer,
//         result consumer) - drives in_*/coef_we/coef_addr/coef_data.
// slave : the filter itself - drives in_ready, coef_err and out_*.
// Signals:
//   in_valid/in_ch/in_data/in_ready   sample offer and acceptance
//   coef_we/coef_addr/coef_data       coefficient write port
//   coef_err                          one-cycle pulse for a rejected write
//   out_valid/out_ch/out_data         one-cycle result strobe and payload
interface fir_sym_mac_if
    import fir_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int NTAPS = 21,
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int OW    = 20
);
    localparam int CHW = chw_of(N_CH);
    localparam int AW  = kw_of(NTAPS);

    logic           in_valid;
    logic [CHW-1:0] in_ch;
    logic [DW-1:0]  in_data;
    logic           in_ready;
    logic           coef_we;
    logic [AW-1:0]  coef_addr;
    logic [CW-1:0]  coef_data;
    logic           coef_err;
    logic           out_valid;
    logic [CHW-1:0] out_ch;
    logic [OW-1:0]  out_data;

    modport master (
        output in_valid, in_ch, in_data, coef_we, coef_addr, coef_data,
        input  in_ready, coef_err, out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_ch, in_data, coef_we, coef_addr, coef_data,
        output in_ready, coef_err, out_valid, out_ch, out_data
    );

endinterface

// File: rtl/fir_hist_bank.sv
// Per-channel sample history for the symmetric FIR.
// Each channel keeps the last NTAPS samples; x[0] is the newest.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset (clears all history)
//   shift_en     one bit per channel; shifts shift_data into that channel
//   shift_data   sample to shift in
//   rd_ch, rd_k  channel and tap index for the two read ports
//   rd_near      x[rd_k] of channel rd_ch
//   rd_far       x[NTAPS-1-rd_k] of channel rd_ch (the mirrored tap)
module fir_hist_bank
    import fir_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int NTAPS = 21,
    parameter int DW    = 8,
    parameter int CHW   = chw_of(N_CH),
    parameter int KW    = kw_of(NTAPS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] shift_en,
    input  logic [DW-1:0]   shift_data,
    input  logic [CHW-1:0]  rd_ch,
    input  logic [KW-1:0]   rd_k,
    output logic [DW-1:0]   rd_near,
    output logic [DW-1:0]   rd_far
);

    logic [DW-1:0] hist [N_CH][NTAPS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int t = 0; t < NTAPS; t++) begin
                    hist[c][t] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (shift_en[c]) begin
                    hist[c][0] <= shift_data;
                    for (int t = 1; t < NTAPS; t++) begin
                        hist[c][t] <= hist[c][t-1];
                    end
                end
            end
        end
    end

    // Read muxes are written as compare loops so that an index beyond the
    // array never forms an out-of-range access.
    always_comb begin
        rd_near = '0;
        rd_far  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (32'(rd_ch) == c) begin
                for (int t = 0; t < NTAPS; t++) begin
                    if (32'(rd_k) == t) begin
                        rd_near = hist[c][t];
                    end
                    if ((NTAPS - 1 - 32'(rd_k)) == t) begin
                        rd_far = hist[c][t];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fir_sym_mac.sv
// N_CH-channel symmetric linear-phase FIR sharing one multiply-accumulate.
// An accepted sample is shifted into its channel history, then HALF+1 MAC
// cycles fold each mirrored tap pair through a pre-adder (the centre tap is
// taken once), and a DONE cycle publishes the saturated result.
// Ports:
//   CLK_Filter   sole clock, rising edge
//   rst_n        synchronous active-low reset; aborts any computation and
//                reloads the default coefficients
//   bus          fir_sym_mac_if slave modport (sample in, coefficient
//                write, coef_err, result out)
module fir_sym_mac
    import fir_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int NTAPS = 21,
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int OW    = 20
) (
    input  logic         CLK_Filter,
    input  logic         rst_n,
    fir_sym_mac_if.slave bus
);

    localparam int HALF = half_of(NTAPS);
    localparam int CHW  = chw_of(N_CH);
    localparam int KW   = kw_of(NTAPS);
    localparam int ACCW = accw_of(DW, CW, NTAPS);
    localparam int PW   = DW + 1 + CW;
    localparam int SW   = (ACCW > OW) ? ACCW : OW;
    localparam logic [SW-1:0] OUT_MAX = SW'({OW{1'b1}});

    state_t          state;
    state_t          state_nxt;
    logic [KW-1:0]   k;
    logic [CHW-1:0]  cur_ch;
    logic [ACCW-1:0] acc;
    logic [CW-1:0]   coef [HALF+1];

    logic            accept;
    logic            coef_ok;
    logic            coef_bad;
    logic            last_k;
    logic [N_CH-1:0] shift_en;
    logic [DW-1:0]   rd_near;
    logic [DW-1:0]   rd_far;
    logic [CW-1:0]   coef_k;
    logic [DW:0]     pre;
    logic [PW-1:0]   prod;
    logic [SW-1:0]   acc_ext;
    logic [OW-1:0]   sat_data;

    logic            out_valid_r;
    logic [CHW-1:0]  out_ch_r;
    logic [OW-1:0]   out_data_r;
    logic            coef_err_r;

    // Ready is forced low while reset is held so nothing looks acceptable.
    assign bus.in_ready  = rst_n && (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_ch    = out_ch_r;
    assign bus.out_data  = out_data_r;
    assign bus.coef_err  = coef_err_r;

    // Samples for a non-existent channel are dropped without leaving IDLE.
    assign accept   = (state == IDLE) && bus.in_valid && (32'(bus.in_ch) < N_CH);
    assign coef_ok  = (state == IDLE) && bus.coef_we && (32'(bus.coef_addr) <= HALF);
    assign coef_bad = bus.coef_we && !coef_ok;
    assign last_k   = (32'(k) == HALF);

    always_comb begin
        shift_en = '0;
        for (int c = 0; c < N_CH; c++) begin
            shift_en[c] = accept && (32'(bus.in_ch) == c);
        end
    end

    fir_hist_bank #(
        .N_CH  (N_CH),
        .NTAPS (NTAPS),
        .DW    (DW),
        .CHW   (CHW),
        .KW    (KW)
    ) u_hist (
        .clk        (CLK_Filter),
        .rst_n      (rst_n),
        .shift_en   (shift_en),
        .shift_data (bus.in_data),
        .rd_ch      (cur_ch),
        .rd_k       (k),
        .rd_near    (rd_near),
        .rd_far     (rd_far)
    );

    // Coefficient table: defaults at reset, IDLE-only writes afterwards.
    // A write in the same cycle as an accept lands before the first MAC.
    always_ff @(posedge CLK_Filter) begin
        if (!rst_n) begin
            for (int i = 0; i <= HALF; i++) begin
                coef[i] <= CW'(default_coef(i));
            end
        end else begin
            for (int i = 0; i <= HALF; i++) begin
                if (coef_ok && (32'(bus.coef_addr) == i)) begin
                    coef[i] <= bus.coef_data;
                end
            end
        end
    end

    // Pre-adder and multiplier; the centre tap contributes its sample once.
    always_comb begin
        coef_k = '0;
        for (int i = 0; i <= HALF; i++) begin
            if (32'(k) == i) begin
                coef_k = coef[i];
            end
        end
        if (last_k) begin
            pre = {1'b0, rd_near};
        end else begin
            pre = {1'b0, rd_near} + {1'b0, rd_far};
        end
        prod = PW'(coef_k) * PW'(pre);
    end

    // Clamp the accumulator into the output width.
    always_comb begin
        acc_ext = SW'(acc);
        if (acc_ext > OUT_MAX) begin
            sat_data = '1;
        end else begin
            sat_data = acc_ext[OW-1:0];
        end
    end

    // Controller state register.
    always_ff @(posedge CLK_Filter) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> MAC on accept, MAC for HALF+1 cycles, DONE
    // for one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MAC;
            MAC:     if (last_k) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: tap counter, accumulator, result and error strobes.
    always_ff @(posedge CLK_Filter) begin
        if (!rst_n) begin
            k           <= '0;
            acc         <= '0;
            cur_ch      <= '0;
            out_valid_r <= 1'b0;
            out_ch_r    <= '0;
            out_data_r  <= '0;
            coef_err_r  <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            coef_err_r  <= coef_bad;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= '0;
                        k      <= '0;
                        cur_ch <= bus.in_ch;
                    end
                end
                MAC: begin
                    acc <= acc + ACCW'(prod);
                    k   <= k + KW'(1);
                end
                DONE: begin
                    out_valid_r <= 1'b1;
                    out_ch_r    <= cur_ch;
                    out_data_r  <= sat_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sym_mac.sv
// Self-checking bench for fir_sym_mac.
// Two instances share one stimulus stream: one with OW=20 and one with OW=18
// so the saturating path is exercised alongside the exact one. Expected
// results come from a direct convolution over the full symmetric tap set.
module tb_fir_sym_mac;

    localparam int N_CH  = 2;
    localparam int NTAPS = 21;
    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int HALF  = (NTAPS - 1) / 2;
    localparam int LAT   = HALF + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fir_sym_mac_if #(.N_CH(N_CH), .NTAPS(NTAPS), .DW(DW), .CW(CW), .OW(20)) bus_a ();
    fir_sym_mac_if #(.N_CH(N_CH), .NTAPS(NTAPS), .DW(DW), .CW(CW), .OW(18)) bus_b ();

    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.in_ch     = bus_a.in_ch;
    assign bus_b.in_data   = bus_a.in_data;
    assign bus_b.coef_we   = bus_a.coef_we;
    assign bus_b.coef_addr = bus_a.coef_addr;
    assign bus_b.coef_data = bus_a.coef_data;

    fir_sym_mac #(.N_CH(N_CH), .NTAPS(NTAPS), .DW(DW), .CW(CW), .OW(20)) dut_a (
        .CLK_Filter (clk),
        .rst_n      (rst_n),
        .bus        (bus_a)
    );

    fir_sym_mac #(.N_CH(N_CH), .NTAPS(NTAPS), .DW(DW), .CW(CW), .OW(18)) dut_b (
        .CLK_Filter (clk),
        .rst_n      (rst_n),
        .bus        (bus_b)
    );

    int vectors = 0;
    int miscompares = 0;

    int     hist_m [N_CH][NTAPS];
    int     coef_m [HALF+1];
    int     default_tbl [HALF+1] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};
    longint last_a;
    longint last_b;

    task automatic check_output(input string tag, input longint actual, input longint expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++)
            for (int t = 0; t < NTAPS; t++)
                hist_m[c][t] = 0;
        for (int i = 0; i <= HALF; i++)
            coef_m[i] = default_tbl[i];
    endfunction

    // Plain convolution: tap j uses the coefficient of its mirror pair.
    function automatic longint model_out(input int ch);
        longint s = 0;
        for (int j = 0; j < NTAPS; j++) begin
            int idx = (j <= HALF) ? j : (NTAPS - 1 - j);
            s += longint'(coef_m[idx]) * longint'(hist_m[ch][j]);
        end
        return s;
    endfunction

    function automatic longint sat(input longint v, input int ow);
        longint mx = (longint'(1) << ow) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_output("rst_in_ready", bus_a.in_ready, 0);
        check_output("rst_out_valid", bus_a.out_valid, 0);
        check_output("rst_coef_err", bus_a.coef_err, 0);
        check_output("rst_out_data_a", bus_a.out_data, 0);
        check_output("rst_out_data_b", bus_b.out_data, 0);
        check_output("rst_out_ch", bus_a.out_ch, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("rst_release_ready", bus_a.in_ready, 1);
        model_reset();
        last_a = 0;
        last_b = 0;
    endtask

    task automatic write_coef(input int addr, input int data);
        bus_a.coef_we   = 1'b1;
        bus_a.coef_addr = 4'(addr);
        bus_a.coef_data = 8'(data);
        @(posedge clk); #1;
        bus_a.coef_we = 1'b0;
        check_output("coef_err_idle", bus_a.coef_err, (addr > HALF) ? 1 : 0);
        if (addr <= HALF) coef_m[addr] = data;
    endtask

    // Offer one sample (optionally with a same-cycle coefficient write and a
    // write attempt during the MAC phase) and check the resulting strobe.
    task automatic apply_stimulus(input int ch, input int data, input bit we,
                                  input int waddr, input int wdata, input bit mid_we);
        longint exp_a;
        longint exp_b;
        int     lat;
        bus_a.in_valid  = 1'b1;
        bus_a.in_ch     = 1'(ch);
        bus_a.in_data   = 8'(data);
        bus_a.coef_we   = we;
        bus_a.coef_addr = 4'(waddr);
        bus_a.coef_data = 8'(wdata);
        @(posedge clk); #1;
        bus_a.in_valid  = 1'b0;
        bus_a.coef_we   = mid_we;
        bus_a.coef_addr = 4'd0;
        check_output("busy_ready", bus_a.in_ready, 0);
        check_output("strobe_width", bus_a.out_valid, 0);
        check_output("coef_err_accept", bus_a.coef_err, (we && waddr > HALF) ? 1 : 0);
        check_output("hold_data_a", bus_a.out_data, last_a);
        check_output("hold_data_b", bus_b.out_data, last_b);
        if (we && waddr <= HALF) coef_m[waddr] = wdata;
        for (int t = NTAPS - 1; t > 0; t--) hist_m[ch][t] = hist_m[ch][t-1];
        hist_m[ch][0] = data;
        exp_a = sat(model_out(ch), 20);
        exp_b = sat(model_out(ch), 18);
        lat = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                check_output("coef_err_busy", bus_a.coef_err, mid_we ? 1 : 0);
                bus_a.coef_we = 1'b0;
            end
            if (bus_a.out_valid) begin
                lat = cyc;
                break;
            end
        end
        check_output("latency", lat, LAT);
        check_output("out_data_a", bus_a.out_data, exp_a);
        check_output("out_data_b", bus_b.out_data, exp_b);
        check_output("out_ch", bus_a.out_ch, ch);
        check_output("out_valid_b", bus_b.out_valid, 1);
        last_a = exp_a;
        last_b = exp_b;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        bit seen;
        bus_a.in_valid  = 1'b0;
        bus_a.in_ch     = '0;
        bus_a.in_data   = '0;
        bus_a.coef_we   = 1'b0;
        bus_a.coef_addr = '0;
        bus_a.coef_data = '0;
        model_reset();
        last_a = 0;
        last_b = 0;

        $display("[TB] reset and impulse response");
        do_reset();
        apply_stimulus(0, 255, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) apply_stimulus(0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);

        $display("[TB] step response and saturation");
        for (int i = 0; i < 25; i++) apply_stimulus(0, 255, 0, 0, 0, 0);

        $display("[TB] interleaved channels");
        for (int i = 0; i < 22; i++) begin
            apply_stimulus(0, 255, 0, 0, 0, 0);
            apply_stimulus(1, (i == 0) ? 100 : 0, 0, 0, 0, 0);
        end

        $display("[TB] coefficient writes");
        for (int i = 0; i < NTAPS; i++) apply_stimulus(1, 0, 0, 0, 0, 0);
        write_coef(10, 0);
        apply_stimulus(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 0, 0, 0, 0);
        write_coef(11, 5);
        apply_stimulus(0, 17, 0, 0, 77, 1);
        apply_stimulus(0, 3, 1, 10, 128, 0);
        apply_stimulus(1, 9, 1, 11, 200, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 60; i++) begin
            apply_stimulus($urandom_range(0, N_CH - 1), $urandom_range(0, 255),
                           ($urandom_range(0, 3) == 0), $urandom_range(0, HALF + 1),
                           $urandom_range(0, 255), ($urandom_range(0, 4) == 0));
        end

        $display("[TB] reset during MAC");
        bus_a.in_valid = 1'b1;
        bus_a.in_ch    = 1'b0;
        bus_a.in_data  = 8'd200;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        seen = 1'b0;
        @(posedge clk); #1;
        if (bus_a.out_valid) seen = 1'b1;
        check_output("abort_out_data", bus_a.out_data, 0);
        check_output("abort_ready_low", bus_a.in_ready, 0);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            if (bus_a.out_valid) seen = 1'b1;
        end
        check_output("abort_no_valid", seen, 0);
        check_output("abort_ready_back", bus_a.in_ready, 1);
        model_reset();
        last_a = 0;
        last_b = 0;
        apply_stimulus(0, 255, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) apply_stimulus(1, (i == 0) ? 100 : 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
